// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shift/rotate unit, one single-bit step per clock
module seq_shifter #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_q, state_n;
  logic [AMT_W-1:0] cnt_q, cnt_n;
  logic [1:0]       op_q, op_n;
  logic [WIDTH-1:0] y_q, y_n;
  logic             carry_q, carry_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_SHL;
      y_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      op_q    <= op_n;
      y_q     <= y_n;
      carry_q <= carry_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    op_n    = op_q;
    y_n     = y_q;
    carry_n = carry_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_n    = op;
          y_n     = d_in;
          cnt_n   = amt;
          carry_n = 1'b0;
          state_n = (amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        case (op_q)
          OP_SHL: begin
            y_n     = {y_q[WIDTH-2:0], 1'b0};
            carry_n = y_q[WIDTH-1];
          end
          OP_SHR: begin
            y_n     = {1'b0, y_q[WIDTH-1:1]};
            carry_n = y_q[0];
          end
          OP_ROL: begin
            y_n     = {y_q[WIDTH-2:0], y_q[WIDTH-1]};
            carry_n = y_q[WIDTH-1];
          end
          OP_ROR: begin
            y_n     = {y_q[0], y_q[WIDTH-1:1]};
            carry_n = y_q[0];
          end
          default: ;
        endcase
        cnt_n = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // busy/done decode straight from the state register, never from inputs
  assign y     = y_q;
  assign carry = carry_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - scoreboard bench for seq_shifter
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [2:0] amt;
  logic [3:0] d_in;
  logic [3:0] y;
  logic       carry;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  seq_shifter #(.WIDTH(4), .AMT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .amt(amt),
    .d_in(d_in), .y(y), .carry(carry), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: every done pulse pops one expected {y,carry}
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done actual=y%b c%b required=no_done", y, carry);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({y, carry} != e) begin
          errors++;
          $display("FAIL result actual=y%b c%b required=y%b c%b", y, carry, e[4:1], e[0]);
        end
      end
    end
  end

  // launch one op, then wait for done and check latency; returns in first IDLE cycle
  task automatic run(input string name, input logic [3:0] d, input logic [1:0] o,
                     input logic [2:0] a, input logic [3:0] ey, input logic ec);
    int n;
    d_in = d; op = o; amt = a; start = 1'b1;
    exp_q.push_back({ey, ec});
    @(posedge clk); #1;
    start = 1'b0; d_in = 4'hx; op = 2'bxx; amt = 3'bxxx;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    chk({name, "_latency"}, n, int'(a) + 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; amt = 3'd0; d_in = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_y", int'(y), 0);
    chk("reset_carry", int'(carry), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("shl1", 4'b1011, 2'b00, 3'd1, 4'b0110, 1'b1);

    // ROR 3 with intermediate values
    d_in = 4'b1011; op = 2'b11; amt = 3'd3; start = 1'b1;
    exp_q.push_back({4'b0111, 1'b0});
    @(posedge clk); #1;
    start = 1'b0;
    chk("ror_busy", int'(busy), 1);
    @(negedge clk); chk("ror_mid0", int'(y), 4'b1011);
    @(negedge clk); chk("ror_mid1", int'(y), 4'b1101);
    @(negedge clk); chk("ror_mid2", int'(y), 4'b1110);
    @(negedge clk); chk("ror_mid3", int'(y), 4'b0111);
    chk("ror_done_t4", int'(done), 1);
    @(posedge clk); #1;

    run("shr0", 4'b1001, 2'b01, 3'd0, 4'b1001, 1'b0);
    run("shr5", 4'b1111, 2'b01, 3'd5, 4'b0000, 1'b0);
    run("rol4", 4'b1010, 2'b10, 3'd4, 4'b1010, 1'b0);
    run("rol7", 4'b1000, 2'b10, 3'd7, 4'b0100, 1'b0);
    chk("idle_hold_y", int'(y), 4'b0100);

    // starts during SHIFT and during DONE are ignored
    d_in = 4'b0001; op = 2'b00; amt = 3'd3; start = 1'b1;
    exp_q.push_back({4'b1000, 1'b0});
    @(posedge clk); #1;
    d_in = 4'b1111; op = 2'b01; amt = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 40);
      chk("busy_test_done_seen", int'(done), 1);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_ignored", int'(busy), 0);
    @(negedge clk);
    chk("ignored_busy_y", int'(y), 4'b1000);
    chk("ignored_busy_idle", int'(busy), 0);

    // reset in the middle of an operation
    @(posedge clk); #1;
    d_in = 4'b1111; op = 2'b01; amt = 3'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_y", int'(y), 4'b0011);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midop_rst_y", int'(y), 0);
    chk("midop_rst_carry", int'(carry), 0);
    chk("midop_rst_busy", int'(busy), 0);
    chk("midop_rst_done", int'(done), 0);

    run("after_rst", 4'b0101, 2'b10, 3'd1, 4'b1010, 1'b0);
    run("b2b_a", 4'b0011, 2'b00, 3'd1, 4'b0110, 1'b0);
    run("b2b_b", 4'b0001, 2'b11, 3'd1, 4'b1000, 1'b1);

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Multi-cycle shift/rotate unit for the processing unit datapath. It is the sequential counterpart of the combinational single-step shifter: it performs a shift or rotate by a programmable amount, applying one single-bit step per clock. A start/busy/done handshake lets the sequencing control unit launch an operation and wait for its result. It also reports the last bit shifted out, which feeds the flags register.

Parameters:
WIDTH, 4, data word width in bits (≥2)
AMT_W, 3, width of the shift-amount input; amounts 0..2^AMT_W-1

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous active-high reset
start  in  1  launch request; sampled only in IDLE
op  in  2  operation: 00 SHL, 01 SHR, 10 ROL, 11 ROR
amt  in  AMT_W  number of single-bit steps to perform
d_in  in  WIDTH  operand, captured on the accepted start
y  out  WIDTH  working/result register; final value valid while done=1
carry  out  1  last bit shifted or rotated out; 0 if amt=0
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse; result valid

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst; there is no async reset.
- Reset values (rst=1 at an edge): state=IDLE, y=0, carry=0, done=0, busy=0, step counter=0, latched op=00.
- Reset overrides everything, including mid-operation. The operation in flight is discarded with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Latch op, load y<=d_in, load counter<=amt, clear carry.
  - Go to SHIFT if amt!=0, otherwise go to DONE.
- IDLE, start=0: hold y, carry and counter (the last result stays visible).
- SHIFT, each cycle: perform one step on y, update carry, decrement counter. When the counter goes 1→0, go to DONE.
- Step definitions (1 bit per cycle):
  - SHL: y<={y[W-2:0],0}, carry<=y[W-1]
  - SHR: y<={0,y[W-1:1]}, carry<=y[0]
  - ROL: y<={y[W-2:0],y[W-1]}, carry<=y[W-1]
  - ROR: y<={y[0],y[W-1:1]}, carry<=y[0]
- DONE: done=1 for exactly one cycle, busy=1, then unconditionally go to IDLE.
- Latency: start accepted at edge t0; done is high during cycle t0+amt+1. For amt=0, done is high in the cycle right after start.
- start while busy (SHIFT or DONE) is ignored and not queued. start in the same cycle done is high is also ignored. The earliest relaunch is the first IDLE cycle after done.
- Amount ≥ WIDTH is legal and always performs exactly amt steps:
  - Shifts saturate to all zeros.
  - Rotates wrap (ROL by WIDTH+k equals ROL by k).
  - carry follows the step rule on the final step.
- Changes to op, amt or d_in after acceptance have no effect on the operation in progress.
- y shows intermediate values during SHIFT. Consumers read y only when done=1 or in IDLE.
- done and busy are registered outputs (decoded from state registers); there is no combinational path from inputs.

Test Plan:
- Reset, then D=1011, SHL, amt=1, start pulse: done is high 2 cycles after the start edge; y=0110, carry=1; busy=1 for 2 cycles.
- D=1011, ROR, amt=3: intermediate y=1101, 1110, 0111; final y=0111, carry=0; done in cycle t0+4.
- D=1001, SHR, amt=0: done in cycle t0+1, y=1001, carry=0, no SHIFT cycles.
- Saturation and wrap:
  - D=1111, SHR, amt=5: y=0000, carry=0, done at t0+6.
  - D=1010, ROL, amt=4: y=1010, carry=0.
- Busy and reset:
  - Start SHL amt=3 D=0001; pulse start with D=1111 during SHIFT and again during DONE. Result must be y=1000, carry=0, and only one done pulse.
  - Then launch SHR amt=4 and assert rst after 2 steps. Next cycle must show y=0, carry=0, busy=0, done=0, with no done pulse.
  - start in the following cycle must be accepted normally.
- Back-to-back: launch SHL amt=1 D=0011; launch ROR amt=1 D=0001 in the first IDLE cycle after done. Results must be y=0110 then y=1000, carry=0 then 1.
